// File: rtl/sonar_rx_pkg.sv
// sonar_rx_pkg: shared constants and state encodings for the sonar frame
// receiver (bit receiver + ASCII frame parser).
//   ASC_*        7-bit ASCII codes recognised by the parser
//   prs_state_t  parser state, encoding is the db_estado hex-display code
//   rx_state_t   bit receiver state
package sonar_rx_pkg;

  localparam logic [6:0] ASC_0    = 7'h30;
  localparam logic [6:0] ASC_9    = 7'h39;
  localparam logic [6:0] ASC_VIRG = 7'h2C;
  localparam logic [6:0] ASC_FIM  = 7'h23;

  typedef enum logic [3:0] {
    A0     = 4'd0,
    A1     = 4'd1,
    A2     = 4'd2,
    VIRG   = 4'd3,
    D0     = 4'd4,
    D1     = 4'd5,
    D2     = 4'd6,
    TERM   = 4'd7,
    RESYNC = 4'd8
  } prs_state_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP     = 3'd4
  } rx_state_t;

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

endpackage

// File: rtl/sonar_rx_serial_7e2.sv
// sonar_rx_serial_7e2: 7E2 asynchronous serial bit receiver.
//   clock, reset     system clock, synchronous active-high reset
//   rx_serial        asynchronous line, idle high (2-FF synchronised here)
//   byte_valid       one-cycle pulse at the stop-1 mid-bit sample
//   dado[6:0]        received character, valid with byte_valid
//   par_ok           even parity correct (tied 1 unless SONAR_RX_PARITY_CHECK_EN)
//   stop_ok          stop bit 1 sampled high
// Macro SONAR_RX_PARITY_CHECK_EN enables the parity check; without it the
// parity slot is still timed but its value is dropped.
// Stop bit 2 is never sampled: returning to IDLE at stop-1 mid-bit lets the
// next start edge be caught even with only one stop bit on the line.
module sonar_rx_serial_7e2
  import sonar_rx_pkg::*;
#(
  parameter int TICKS_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       byte_valid,
  output logic [6:0] dado,
  output logic       par_ok,
  output logic       stop_ok
);

  localparam int CW = (TICKS_BIT > 2) ? $clog2(TICKS_BIT) : 1;
  localparam logic [CW-1:0] T_FULL = CW'(TICKS_BIT - 1);
  localparam logic [CW-1:0] T_HALF = CW'(TICKS_BIT / 2 - 1);

  logic          rx_m, rx_s, rx_d;
  rx_state_t     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    nbit, nbit_n;
  logic [6:0]    sh, sh_n;
  logic          bv_n, stop_n;

  // 2-FF synchroniser, plus one more stage for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

`ifdef SONAR_RX_PARITY_CHECK_EN
  logic par_q, par_n;
  always_ff @(posedge clock) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_n;
  end
  // even parity: data bits plus parity bit XOR to zero
  assign par_ok = ~(^{sh, par_q});
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      cnt        <= '0;
      nbit       <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      stop_ok    <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      nbit       <= nbit_n;
      sh         <= sh_n;
      byte_valid <= bv_n;
      stop_ok    <= stop_n;
    end
  end

  // counter is reloaded explicitly at every sample point, never wraps
  always_comb begin
    st_n   = st;
    cnt_n  = cnt + 1'b1;
    nbit_n = nbit;
    sh_n   = sh;
    bv_n   = 1'b0;
    stop_n = stop_ok;
`ifdef SONAR_RX_PARITY_CHECK_EN
    par_n  = par_q;
`endif
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) st_n = START;
      end
      START: begin
        if (cnt == T_HALF) begin
          cnt_n  = '0;
          nbit_n = '0;
          st_n   = rx_s ? IDLE : DADOS;  // high at mid-start: false start
        end
      end
      DADOS: begin
        if (cnt == T_FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[6:1]};  // LSB first
          if (nbit == 4'd6) st_n = PARIDADE;
          else              nbit_n = nbit + 4'd1;
        end
      end
      PARIDADE: begin
        if (cnt == T_FULL) begin
          cnt_n = '0;
`ifdef SONAR_RX_PARITY_CHECK_EN
          par_n = rx_s;
`endif
          st_n  = STOP;
        end
      end
      STOP: begin
        if (cnt == T_FULL) begin
          cnt_n  = '0;
          stop_n = rx_s;
          bv_n   = 1'b1;
          st_n   = IDLE;
        end
      end
      default: begin
        cnt_n = '0;
        st_n  = IDLE;
      end
    endcase
  end

  assign dado = sh;

endmodule

// File: rtl/sonar_frame_rx.sv
// sonar_frame_rx: receives the sonar "AAA,DDD#" ASCII measurement message
// over a 7E2 serial line and presents angle/distance as 12-bit BCD.
//   clock, reset   system clock, synchronous active-high reset
//   rx_serial      serial line, idle high
//   angulo         BCD angle of the last valid frame
//   distancia      BCD distance of the last valid frame
//   pronto         one-cycle pulse when angulo/distancia update
//   erro           one-cycle pulse per rejected frame
//   db_estado      parser state code for a hex display
// Optional macro SONAR_RX_PARITY_CHECK_EN (in sonar_rx_serial_7e2) makes
// parity errors reject the frame.
module sonar_frame_rx
  import sonar_rx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int TICKS_BIT = CLK_HZ / BAUD;

  logic       byte_valid, par_ok, stop_ok;
  logic [6:0] dado;

  sonar_rx_serial_7e2 #(.TICKS_BIT(TICKS_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .byte_valid (byte_valid),
    .dado       (dado),
    .par_ok     (par_ok),
    .stop_ok    (stop_ok)
  );

  prs_state_t  st, st_n;
  logic [11:0] sh_ang, sh_ang_n, sh_dist, sh_dist_n;
  logic        pronto_n, erro_n;
  logic        byte_ok, fim_ok, char_ok;

  assign byte_ok = stop_ok & par_ok;
  assign fim_ok  = byte_ok && (dado == ASC_FIM);

  // is this the character the current state expects?
  always_comb begin
    char_ok = 1'b0;
    unique case (st)
      A0, A1, A2, D0, D1, D2: char_ok = is_digit(dado);
      VIRG:                   char_ok = (dado == ASC_VIRG);
      TERM:                   char_ok = (dado == ASC_FIM);
      default:                char_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= A0;
      sh_ang    <= '0;
      sh_dist   <= '0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      angulo    <= '0;
      distancia <= '0;
    end else begin
      st      <= st_n;
      sh_ang  <= sh_ang_n;
      sh_dist <= sh_dist_n;
      pronto  <= pronto_n;
      erro    <= erro_n;
      if (pronto_n) begin
        angulo    <= sh_ang;
        distancia <= sh_dist;
      end
    end
  end

  always_comb begin
    st_n      = st;
    sh_ang_n  = sh_ang;
    sh_dist_n = sh_dist;
    pronto_n  = 1'b0;
    erro_n    = 1'b0;
    if (byte_valid) begin
      if (st == RESYNC) begin
        // silently drop everything until a clean terminator
        if (fim_ok) st_n = A0;
      end else if (byte_ok && char_ok) begin
        unique case (st)
          A0:   begin sh_ang_n[11:8]  = dado[3:0]; st_n = A1;   end
          A1:   begin sh_ang_n[7:4]   = dado[3:0]; st_n = A2;   end
          A2:   begin sh_ang_n[3:0]   = dado[3:0]; st_n = VIRG; end
          VIRG: st_n = D0;
          D0:   begin sh_dist_n[11:8] = dado[3:0]; st_n = D1;   end
          D1:   begin sh_dist_n[7:4]  = dado[3:0]; st_n = D2;   end
          D2:   begin sh_dist_n[3:0]  = dado[3:0]; st_n = TERM; end
          TERM: begin pronto_n = 1'b1; st_n = A0; end
          default: st_n = RESYNC;
        endcase
      end else begin
        // a clean '#' already marks a frame boundary, so no resync needed
        erro_n    = 1'b1;
        sh_ang_n  = '0;
        sh_dist_n = '0;
        st_n      = fim_ok ? A0 : RESYNC;
      end
    end
  end

  assign db_estado = st;

endmodule

// File: tb/tb_sonar_frame_rx.sv
module tb_sonar_frame_rx;
  import sonar_rx_pkg::*;

  localparam int TB = 16;  // 1_843_200 / 115_200

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_serial;
  logic [11:0] angulo, distancia;
  logic        pronto, erro;
  logic [3:0]  db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pronto = 0, n_erro = 0, n_both = 0;

  sonar_frame_rx #(.CLK_HZ(1_843_200), .BAUD(115_200)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_serial (rx_serial),
    .angulo    (angulo),
    .distancia (distancia),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pronto === 1'b1) n_pronto++;
    if (erro === 1'b1) n_erro++;
    if (pronto === 1'b1 && erro === 1'b1) n_both++;
  end

  task automatic send_byte(input logic [6:0] c, input bit flip_par, input bit bad_stop, input int nstop);
    logic p;
    p = (^c) ^ flip_par;
    rx_serial = 1'b0; repeat (TB) @(posedge clock);
    for (int i = 0; i < 7; i++) begin
      rx_serial = c[i]; repeat (TB) @(posedge clock);
    end
    rx_serial = p;         repeat (TB) @(posedge clock);
    rx_serial = ~bad_stop; repeat (TB) @(posedge clock);
    rx_serial = 1'b1;      repeat (TB * (nstop - 1)) @(posedge clock);
  endtask

  task automatic send_str(input string s, input int flip_i, input int bad_i, input int nstop);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_byte(b[6:0], i == flip_i, i == bad_i, nstop);
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [11:0] ea, input logic [11:0] ed);
    n_tests++;
    if (angulo !== ea) begin
      n_fail++; $display("FAIL %s angulo: got %h want %h", name, angulo, ea);
    end
    n_tests++;
    if (distancia !== ed) begin
      n_fail++; $display("FAIL %s distancia: got %h want %h", name, distancia, ed);
    end
  endtask

  task automatic chk_cnt(input string name, input int p0, input int e0, input int dp, input int de, input logic [3:0] est);
    n_tests++;
    if (n_pronto - p0 !== dp) begin
      n_fail++; $display("FAIL %s pronto pulses: got %0d want %0d", name, n_pronto - p0, dp);
    end
    n_tests++;
    if (n_erro - e0 !== de) begin
      n_fail++; $display("FAIL %s erro pulses: got %0d want %0d", name, n_erro - e0, de);
    end
    n_tests++;
    if (db_estado !== est) begin
      n_fail++; $display("FAIL %s db_estado: got %0d want %0d", name, db_estado, est);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_serial = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk_out("reset", 12'h000, 12'h000);
    n_tests++;
    if ({pronto, erro, db_estado} !== 6'b0) begin
      n_fail++; $display("FAIL reset flags: got %b want 000000", {pronto, erro, db_estado});
    end
    reset = 1'b0;
    repeat (TB * 2) @(posedge clock); #1;
  endtask

  task automatic test_valid_frame();
    int p0 = n_pronto, e0 = n_erro;
    send_str("090,025#", -1, -1, 2);
    chk_cnt("valid", p0, e0, 1, 0, 4'd0);
    chk_out("valid", 12'h090, 12'h025);
  endtask

  task automatic test_parity();
    int p0 = n_pronto, e0 = n_erro;
    send_str("090,025#", 5, -1, 2);
`ifdef SONAR_RX_PARITY_CHECK_EN
    chk_cnt("parity_bad", p0, e0, 0, 1, 4'd0);
`else
    chk_cnt("parity_ign", p0, e0, 1, 0, 4'd0);
`endif
    chk_out("parity", 12'h090, 12'h025);
    p0 = n_pronto; e0 = n_erro;
    send_str("135,110#", -1, -1, 2);
    chk_cnt("parity_next", p0, e0, 1, 0, 4'd0);
    chk_out("parity_next", 12'h135, 12'h110);
  endtask

  task automatic test_bad_char();
    int p0 = n_pronto, e0 = n_erro;
    send_str("09A", -1, -1, 2);
    chk_cnt("badchar_A", p0, e0, 0, 1, 4'd8);
    send_str(",025#", -1, -1, 2);
    chk_cnt("badchar_rest", p0, e0, 0, 1, 4'd0);
    chk_out("badchar_hold", 12'h135, 12'h110);
    p0 = n_pronto; e0 = n_erro;
    send_str("045,300#", -1, -1, 2);
    chk_cnt("badchar_next", p0, e0, 1, 0, 4'd0);
    chk_out("badchar_next", 12'h045, 12'h300);
  endtask

  task automatic test_early_term();
    int p0 = n_pronto, e0 = n_erro;
    send_str("09#", -1, -1, 2);
    chk_cnt("early", p0, e0, 0, 1, 4'd0);
    p0 = n_pronto; e0 = n_erro;
    send_str("180,007#", -1, -1, 2);
    chk_cnt("early_next", p0, e0, 1, 0, 4'd0);
    chk_out("early_next", 12'h180, 12'h007);
  endtask

  task automatic test_glitch_stop();
    int p0 = n_pronto, e0 = n_erro;
    send_str("2", -1, -1, 2);
    rx_serial = 1'b0; repeat (5) @(posedge clock);  // ~0.3 bit
    rx_serial = 1'b1; repeat (TB * 12) @(posedge clock); #1;
    chk_cnt("glitch", p0, e0, 0, 0, 4'd1);
    send_str("34,567#", -1, -1, 2);
    chk_cnt("glitch_frame", p0, e0, 1, 0, 4'd0);
    chk_out("glitch_frame", 12'h234, 12'h567);
    p0 = n_pronto; e0 = n_erro;
    send_str("123,", -1, 3, 2);
    chk_cnt("stop_bad", p0, e0, 0, 1, 4'd8);
    send_str("#", -1, -1, 2);
    chk_cnt("stop_resync", p0, e0, 0, 1, 4'd0);
    chk_out("stop_hold", 12'h234, 12'h567);
  endtask

  task automatic test_back_to_back();
    int p0 = n_pronto, e0 = n_erro;
    send_str("777,888#", -1, -1, 1);
    send_str("456,789#", -1, -1, 1);
    chk_cnt("b2b", p0, e0, 2, 0, 4'd0);
    chk_out("b2b", 12'h456, 12'h789);
  endtask

  task automatic test_reset_mid();
    int p0, e0;
    send_str("090,0", -1, -1, 2);
    @(posedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk_out("rst_mid", 12'h000, 12'h000);
    n_tests++;
    if (db_estado !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid db_estado: got %0d want 0", db_estado);
    end
    @(posedge clock); reset = 1'b0;
    repeat (TB * 2) @(posedge clock); #1;
    p0 = n_pronto; e0 = n_erro;
    send_str("010,020#", -1, -1, 2);
    chk_cnt("rst_mid_next", p0, e0, 1, 0, 4'd0);
    chk_out("rst_mid_next", 12'h010, 12'h020);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity();
    test_bad_char();
    test_early_term();
    test_glitch_stop();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (n_both !== 0) begin
      n_fail++; $display("FAIL pronto_erro_overlap: got %0d want 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
